spike_bin_loader: RTL and testbench

SPIKE_BIN_LOADER -- requirements
Module: spike_bin_loader

---
 rtl/spike_bin_loader.sv | 118 +++++++++++
 tb/tb_spike_bin_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_bin_loader.sv
// Bins spike events into two ping-pong counter banks and dumps the idle bank into the decoder data RAM.
// Build option: define SPIKE_CNT_SAT_EN to make counters saturate instead of wrapping.
module spike_bin_loader #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned COL_NUM   = 128,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned BIN_TICKS = 50,
  localparam int unsigned ADDR_W   = $clog2(COL_NUM) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              spk_v,
  input  logic [ADDR_W-1:0] spk_ch,
  input  logic              dec_busy,
  output logic [ADDR_W-1:0] wr_data_addr,
  output logic              ram_wr_data_en,
  output logic [WIDTH-1:0]  ram_data_wr_in,
  output logic              start,
  output logic              bin_overrun,
  output logic              bank_sel
);

  localparam int unsigned IDX_W  = ADDR_W - 1;
  localparam int unsigned TICK_W = $clog2(BIN_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_DEC, S_DUMP, S_START} state_t;

  state_t                               r_state;
  state_t                               w_next;
  logic [TICK_W-1:0]                    r_tick_cnt;
  logic [IDX_W-1:0]                     r_idx;
  logic [1:0][COL_NUM-1:0][CNT_W-1:0]   r_cnt;
  logic                                 r_bank_sel;

  logic             w_bin_end;
  logic             w_swap;
  logic             w_spk_ok;
  logic [IDX_W-1:0] w_spk_idx;
  logic             w_inc_bank;
  logic             w_dump_bank;
  logic [CNT_W-1:0] w_cur;
  logic [CNT_W-1:0] w_inc;
  logic             w_last;

  assign bank_sel    = r_bank_sel;
  assign w_bin_end   = tick && (r_tick_cnt == TICK_W'(BIN_TICKS - 1));
  assign w_swap      = w_bin_end && (r_state == S_IDLE);
  assign w_spk_ok    = spk_v && (spk_ch < ADDR_W'(COL_NUM));
  assign w_spk_idx   = spk_ch[IDX_W-1:0];
  // A spike on the swap edge already belongs to the new bin.
  assign w_inc_bank  = r_bank_sel ^ w_swap;
  assign w_dump_bank = ~r_bank_sel;
  assign w_cur       = r_cnt[w_inc_bank][w_spk_idx];
  assign w_last      = (r_idx == IDX_W'(COL_NUM - 1));

`ifdef SPIKE_CNT_SAT_EN
  assign w_inc = (w_cur == {CNT_W{1'b1}}) ? w_cur : w_cur + CNT_W'(1);
`else
  assign w_inc = w_cur + CNT_W'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_swap) w_next = S_WAIT_DEC;
      S_WAIT_DEC: if (!dec_busy) w_next = S_DUMP;
      S_DUMP:     if (w_last) w_next = S_START;
      S_START:    w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Bin timing and bank ownership
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_bank_sel <= 1'b0;
    end else begin
      if (tick) r_tick_cnt <= w_bin_end ? '0 : r_tick_cnt + TICK_W'(1);
      if (w_swap) r_bank_sel <= ~r_bank_sel;
    end
  end

  // Counting and clear-on-dump touch different banks, since no swap happens mid-dump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      if (w_spk_ok) r_cnt[w_inc_bank][w_spk_idx] <= w_inc;
      if (r_state == S_DUMP) r_cnt[w_dump_bank][r_idx] <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx          <= '0;
      ram_wr_data_en <= 1'b0;
      wr_data_addr   <= '0;
      ram_data_wr_in <= '0;
      start          <= 1'b0;
      bin_overrun    <= 1'b0;
    end else begin
      r_idx          <= (r_state == S_DUMP && !w_last) ? r_idx + IDX_W'(1) : '0;
      ram_wr_data_en <= (r_state == S_DUMP);
      wr_data_addr   <= (r_state == S_DUMP) ? {1'b0, r_idx} : '0;
      ram_data_wr_in <= (r_state == S_DUMP) ? WIDTH'(r_cnt[w_dump_bank][r_idx]) : '0;
      start          <= (r_state == S_START);
      bin_overrun    <= w_bin_end && (r_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_spike_bin_loader.sv
// Self-checking bench for spike_bin_loader: table-driven bins plus directed latency, overrun and reset sequences.
module tb_spike_bin_loader;

  localparam int COLS = 128;
  localparam int BT   = 3;
`ifdef SPIKE_CNT_SAT_EN
  localparam int W300 = 255;
  localparam int W256 = 255;
`else
  localparam int W300 = 44;
  localparam int W256 = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, tick, spk_v, dec_busy;
  logic [7:0]  spk_ch;
  logic [7:0]  wr_data_addr;
  logic        ram_wr_data_en;
  logic [15:0] ram_data_wr_in;
  logic        start, bin_overrun, bank_sel;

  spike_bin_loader #(.WIDTH(16), .COL_NUM(COLS), .CNT_W(8), .BIN_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .spk_v(spk_v), .spk_ch(spk_ch),
    .dec_busy(dec_busy), .wr_data_addr(wr_data_addr), .ram_wr_data_en(ram_wr_data_en),
    .ram_data_wr_in(ram_data_wr_in), .start(start), .bin_overrun(bin_overrun),
    .bank_sel(bank_sel)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int data;} wr_t;
  typedef struct {int ch_a; int n_a; int ch_b; int n_b; int chk; int exp;} vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t tbl[4];
  int   errors = 0, checks = 0, cyc = 0;
  int   m_cnt[COLS];
  int   cap[COLS];
  int   tcnt = 0, exp_ovr = 0, obs_ovr = 0, n_writes = 0, start_count = 0;
  int   first_wr_cyc = -1, start_cyc = -1, swap_cyc = 0;
  bit   dump_pending = 1'b0, exp_bank = 1'b0, prev_wr127 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int word_of(input int c);
`ifdef SPIKE_CNT_SAT_EN
    return (c > 255) ? 255 : c;
`else
    return c % 256;
`endif
  endfunction

  // Scoreboard: every write pops the expected {addr, word} queued at bin end.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_wr_data_en) begin
        n_writes++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        cap[wr_data_addr[6:0]] = int'(ram_data_wr_in);
        if (exp_q.size() == 0) begin
          check("unexpected_write", int'(wr_data_addr), -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", int'(wr_data_addr), mon_e.addr);
          check("wr_data", int'(ram_data_wr_in), mon_e.data);
        end
      end else begin
        check("idle_addr", int'(wr_data_addr), 0);
      end
      if (start) begin
        start_count++;
        start_cyc = cyc;
        check("start_after_127", int'(prev_wr127), 1);
        dump_pending = 1'b0;
      end
      if (bin_overrun) obs_ovr++;
      prev_wr127 = ram_wr_data_en && (wr_data_addr == 8'd127);
    end
  end

  // Drives one cycle and advances the reference model at the same edge the DUT sees it.
  task automatic drive(input bit t, input bit sv, input int ch);
    tick = t; spk_v = sv; spk_ch = 8'(ch);
    if (t) begin
      if (tcnt == BT - 1) begin
        tcnt = 0;
        if (!dump_pending) begin
          for (int i = 0; i < COLS; i++) begin
            exp_q.push_back('{i, word_of(m_cnt[i])});
            m_cnt[i] = 0;
          end
          dump_pending = 1'b1;
          exp_bank = ~exp_bank;
          swap_cyc = cyc + 1;
        end else begin
          exp_ovr++;
        end
      end else begin
        tcnt++;
      end
    end
    if (sv && ch < COLS) m_cnt[ch]++;
    @(negedge clk);
    tick = 1'b0; spk_v = 1'b0; spk_ch = 8'd0;
  endtask

  task automatic spikes(input int ch, input int n);
    repeat (n) drive(1'b0, 1'b1, ch);
  endtask

  task automatic end_bin();
    repeat (BT) drive(1'b1, 1'b0, 0);
  endtask

  task automatic wait_dump_done();
    int sc = start_count;
    for (int i = 0; i < 600 && start_count == sc; i++) begin
      @(negedge clk); #1;
    end
    check("dump_start_seen", start_count - sc, 1);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kdrop, n0, sc, ovr0;
    bit found;
    tbl[0] = '{3, 5, 127, 2, 3, 5};
    tbl[1] = '{0, 300, 1, 1, 0, W300};
    tbl[2] = '{200, 4, 72, 3, 72, 3};
    tbl[3] = '{127, 256, 126, 255, 127, W256};
    for (int i = 0; i < COLS; i++) begin m_cnt[i] = 0; cap[i] = -1; end
    rst = 1'b1; tick = 1'b0; spk_v = 1'b0; spk_ch = 8'd0; dec_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", int'(ram_wr_data_en), 0);
    check("rst_addr", int'(wr_data_addr), 0);
    check("rst_data", int'(ram_data_wr_in), 0);
    check("rst_start", int'(start), 0);
    check("rst_overrun", int'(bin_overrun), 0);
    check("rst_bank", int'(bank_sel), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      spikes(tbl[v].ch_a, tbl[v].n_a);
      spikes(tbl[v].ch_b, tbl[v].n_b);
      repeat (BT - 1) drive(1'b1, 1'b0, 0);
      check("bank_before_bin_end", int'(bank_sel), int'(exp_bank));
      first_wr_cyc = -1;
      drive(1'b1, 1'b0, 0);
      check("bank_after_swap", int'(bank_sel), int'(exp_bank));
      wait_dump_done();
      check($sformatf("tbl%0d_word", v), cap[tbl[v].chk], tbl[v].exp);
      if (v == 0) begin
        check("tbl0_addr127", cap[127], 2);
        check("first_write_latency", first_wr_cyc - swap_cyc, 2);
        check("start_latency", start_cyc - swap_cyc, COLS + 2);
      end
    end

    // Spike on the swap edge goes to the new bin; out-of-range channel is dropped.
    spikes(7, 1);
    repeat (BT - 1) drive(1'b1, 1'b0, 0);
    drive(1'b1, 1'b1, 5);
    wait_dump_done();
    check("swap_spike_not_current", cap[5], 0);
    spikes(200, 3);
    end_bin();
    wait_dump_done();
    check("swap_spike_next_bin", cap[5], 1);

    // Decoder busy holds the dump off.
    dec_busy = 1'b1;
    spikes(20, 4);
    end_bin();
    n0 = n_writes;
    repeat (300) @(negedge clk);
    check("no_writes_while_busy", n_writes - n0, 0);
    first_wr_cyc = -1;
    kdrop = cyc;
    dec_busy = 1'b0;
    wait_dump_done();
    check("busy_first_write", first_wr_cyc - kdrop, 2);
    check("busy_start", start_cyc - kdrop, COLS + 2);
    check("busy_write_count", n_writes - n0, COLS);
    check("busy_word", cap[20], 4);

    // Bin end during a dump merges bins and pulses overrun.
    spikes(9, 3);
    end_bin();
    ovr0 = obs_ovr;
    spikes(9, 10);
    end_bin();
    repeat (2) @(negedge clk);
    check("overrun_pulse", obs_ovr - ovr0, 1);
    check("overrun_no_swap", int'(bank_sel), int'(exp_bank));
    spikes(9, 5);
    wait_dump_done();
    check("overrun_first_dump", cap[9], 3);
    end_bin();
    wait_dump_done();
    check("overrun_merged_dump", cap[9], 15);

    // Reset in the middle of a dump aborts it.
    spikes(10, 6);
    end_bin();
    spikes(11, 2);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk); #1;
      if (ram_wr_data_en && wr_data_addr == 8'd40) found = 1'b1;
    end
    check("reached_addr40", int'(found), 1);
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < COLS; i++) m_cnt[i] = 0;
    tcnt = 0; dump_pending = 1'b0; exp_bank = 1'b0;
    sc = start_count; n0 = n_writes;
    @(negedge clk);
    check("rst_mid_wr_en", int'(ram_wr_data_en), 0);
    check("rst_mid_bank", int'(bank_sel), 0);
    rst = 1'b0;
    repeat (140) @(negedge clk);
    check("abort_no_start", start_count - sc, 0);
    check("abort_no_writes", n_writes - n0, 0);
    spikes(12, 4);
    end_bin();
    wait_dump_done();
    check("post_rst_old_bank", cap[10], 0);
    check("post_rst_old_active", cap[11], 0);
    check("post_rst_new", cap[12], 4);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("overrun_total", obs_ovr, exp_ovr);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
